// File: rtl/cache_mem_controller_if.sv
// Bundle of requester-side and backing-memory-side signals for cache_mem_controller.
// The controller uses the master view; the surrounding CPU/memory uses the slave view.
interface cache_mem_controller_if;
    logic         cacheMiss;
    logic         cacheEvict;
    logic [31:0]  missAddr;
    logic [31:0]  evictAddr;
    logic [511:0] evictBlk;
    logic [511:0] mcDataOut;
    logic         mcDataValid;
    logic         evictDone;
    logic         memReq;
    logic         memWr;
    logic [31:0]  memAddr;
    logic [31:0]  memWrData;
    logic         memAck;
    logic [31:0]  memRdData;

    modport master (
        input  cacheMiss, cacheEvict, missAddr, evictAddr, evictBlk, memAck, memRdData,
        output mcDataOut, mcDataValid, evictDone, memReq, memWr, memAddr, memWrData
    );

    modport slave (
        output cacheMiss, cacheEvict, missAddr, evictAddr, evictBlk, memAck, memRdData,
        input  mcDataOut, mcDataValid, evictDone, memReq, memWr, memAddr, memWrData
    );
endinterface

// File: rtl/cache_mem_controller.sv
// Cache-block evict/fill responder: moves 512-bit blocks as 16 word beats on the memory port.
// An evict is always followed by a fill of the miss block latched alongside it.
module cache_mem_controller (
    input  logic                   clk,
    input  logic                   rst,
    cache_mem_controller_if.master bus
);
    typedef enum logic [2:0] {
        StIdle,
        StEvict,
        StEvictDone,
        StLoad,
        StLoadDone
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   beat_q, beat_d;
    logic [25:0]  ev_base_q, ev_base_d;
    logic [25:0]  miss_base_q, miss_base_d;
    logic [511:0] ev_blk_q, ev_blk_d;
    logic [511:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= 4'd0;
            ev_base_q   <= 26'd0;
            miss_base_q <= 26'd0;
            ev_blk_q    <= 512'd0;
            data_q      <= 512'd0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            ev_base_q   <= ev_base_d;
            miss_base_q <= miss_base_d;
            ev_blk_q    <= ev_blk_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        ev_base_d   = ev_base_q;
        miss_base_d = miss_base_q;
        ev_blk_d    = ev_blk_q;
        data_d      = data_q;
        unique case (state_q)
            StIdle: begin
                // Evict wins; the miss base is captured now so the fill follows without re-request.
                if (bus.cacheEvict) begin
                    ev_base_d   = bus.evictAddr[31:6];
                    ev_blk_d    = bus.evictBlk;
                    miss_base_d = bus.missAddr[31:6];
                    beat_d      = 4'd0;
                    state_d     = StEvict;
                end else if (bus.cacheMiss) begin
                    miss_base_d = bus.missAddr[31:6];
                    beat_d      = 4'd0;
                    state_d     = StLoad;
                end
            end
            StEvict: begin
                if (bus.memAck) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == 4'd15) state_d = StEvictDone;
                end
            end
            StEvictDone: begin
                beat_d  = 4'd0;
                state_d = StLoad;
            end
            StLoad: begin
                if (bus.memAck) begin
                    data_d[{beat_q, 5'b00000} +: 32] = bus.memRdData;
                    beat_d = beat_q + 4'd1;
                    if (beat_q == 4'd15) state_d = StLoadDone;
                end
            end
            StLoadDone: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs depend only on registered state so requester inputs never reach the memory port.
    always_comb begin
        bus.memReq      = 1'b0;
        bus.memWr       = 1'b0;
        bus.memAddr     = 32'd0;
        bus.memWrData   = 32'd0;
        bus.evictDone   = 1'b0;
        bus.mcDataValid = 1'b0;
        unique case (state_q)
            StEvict: begin
                bus.memReq    = 1'b1;
                bus.memWr     = 1'b1;
                bus.memAddr   = {ev_base_q, beat_q, 2'b00};
                bus.memWrData = ev_blk_q[{beat_q, 5'b00000} +: 32];
            end
            StEvictDone: bus.evictDone = 1'b1;
            StLoad: begin
                bus.memReq  = 1'b1;
                bus.memAddr = {miss_base_q, beat_q, 2'b00};
            end
            StLoadDone: bus.mcDataValid = 1'b1;
            default: ;
        endcase
    end

    assign bus.mcDataOut = data_q;
endmodule

// File: tb/tb_cache_mem_controller.sv
// Randomized bench for cache_mem_controller: a word-addressed memory model plus a per-transaction
// beat-sequence model predict every memory-port cycle, done pulse and the assembled fill block.
module tb_cache_mem_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_mem_controller_if bus ();

    cache_mem_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned  vectors = 0;
    int unsigned  errors  = 0;
    logic [511:0] last_blk;
    logic [31:0]  mem_model [int unsigned];

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5a5a_c3c3;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req"}, bus.memReq, 1'b0);
        check_eq({tag, "_wr"}, bus.memWr, 1'b0);
        check_eq({tag, "_addr"}, bus.memAddr, 32'd0);
        check_eq({tag, "_wdata"}, bus.memWrData, 32'd0);
        check_eq({tag, "_edone"}, bus.evictDone, 1'b0);
        check_eq({tag, "_valid"}, bus.mcDataValid, 1'b0);
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the next idle cycle,
    // or straight after asserting reset when abort_beat is reached.
    task automatic run_txn(input bit evict, input bit miss_req, input logic [31:0] ev_addr,
                           input logic [31:0] ms_addr, input logic [511:0] blk,
                           input int max_stall, input bit hold, input bit pulse_miss,
                           input int abort_beat);
        int phase, widx, ridx, idx, cyc, stall;
        bit fresh, wr;
        logic [31:0] ev_base, ms_base, exp_addr;
        ev_base = ev_addr & ~32'h3f;
        ms_base = ms_addr & ~32'h3f;
        bus.cacheEvict = evict;
        bus.cacheMiss  = miss_req;
        bus.evictAddr  = ev_addr;
        bus.missAddr   = ms_addr;
        bus.evictBlk   = blk;
        phase = evict ? 0 : 2;
        widx = 0; ridx = 0; cyc = 0; stall = 0; fresh = 1'b1;
        @(posedge clk);
        while (phase < 4 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            bus.cacheEvict = 1'b0;
            bus.cacheMiss  = hold ? 1'b1 : (pulse_miss && phase < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.evictAddr  = $urandom;
            bus.missAddr   = $urandom;
            bus.memAck     = 1'b0;
            bus.memRdData  = $urandom;
            case (phase)
                0, 2: begin
                    wr  = (phase == 0);
                    idx = wr ? widx : ridx;
                    exp_addr = (wr ? ev_base : ms_base) + 32'(4 * idx);
                    if (!wr && idx == abort_beat && fresh) begin
                        rst = 1'b1;
                        #1;
                        check_quiet("abort");
                        check_eq("abort_data", bus.mcDataOut, 512'd0);
                        last_blk = '0;
                        bus.cacheMiss = 1'b0;
                        return;
                    end
                    check_eq("beat_req", bus.memReq, 1'b1);
                    check_eq("beat_wr", bus.memWr, wr);
                    check_eq("beat_addr", bus.memAddr, exp_addr);
                    check_eq("beat_pulses", {bus.evictDone, bus.mcDataValid}, 2'b00);
                    if (wr) check_eq("beat_wdata", bus.memWrData, blk[32*idx +: 32]);
                    else    check_eq("fill_hold", bus.mcDataOut, last_blk);
                    if (fresh) begin
                        stall = $urandom_range(0, max_stall);
                        fresh = 1'b0;
                    end
                    if (stall == 0) begin
                        bus.memAck = 1'b1;
                        fresh = 1'b1;
                        if (wr) begin
                            mem_model[exp_addr] = blk[32*idx +: 32];
                            widx++;
                            if (widx == 16) phase = 1;
                        end else begin
                            bus.memRdData = mem_rd(exp_addr);
                            last_blk[32*idx +: 32] = bus.memRdData;
                            ridx++;
                            if (ridx == 16) phase = 3;
                        end
                    end else begin
                        stall--;
                    end
                end
                1: begin
                    check_eq("evict_done", bus.evictDone, 1'b1);
                    check_eq("edone_req", bus.memReq, 1'b0);
                    check_eq("edone_valid", bus.mcDataValid, 1'b0);
                    if (max_stall == 0) check_eq("edone_cycle", cyc, 17);
                    phase = 2;
                end
                default: begin
                    check_eq("valid", bus.mcDataValid, 1'b1);
                    check_eq("valid_edone", bus.evictDone, 1'b0);
                    check_eq("valid_req", bus.memReq, 1'b0);
                    check_eq("fill_data", bus.mcDataOut, last_blk);
                    if (max_stall == 0) check_eq("valid_cycle", cyc, evict ? 34 : 17);
                    phase = 4;
                end
            endcase
        end
        if (phase != 4) check_eq("timeout", phase, 4);
        @(negedge clk);
        bus.memAck = 1'b0;
        check_quiet("idle");
        check_eq("idle_data", bus.mcDataOut, last_blk);
        if (!hold) begin
            @(negedge clk);
            check_quiet("no_extra");
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        logic [511:0] blk;
        logic [31:0]  ea, ma;
        rst = 1'b1;
        bus.cacheMiss = 1'b0; bus.cacheEvict = 1'b0;
        bus.missAddr = '0; bus.evictAddr = '0; bus.evictBlk = '0;
        bus.memAck = 1'b0; bus.memRdData = '0;
        last_blk = '0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check_eq("reset_data", bus.mcDataOut, 512'd0);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");

        // Directed fill.
        for (int i = 0; i < 16; i++) mem_model[32'h2000_0040 + 32'(4 * i)] = 32'h1000 + 32'(i);
        run_txn(1'b0, 1'b1, 32'h0, 32'h2000_0044, '0, 0, 1'b0, 1'b0, -1);
        check_eq("fill_w0", bus.mcDataOut[31:0], 32'h1000);
        check_eq("fill_w15", bus.mcDataOut[511:480], 32'h100F);

        // Directed evict then fill.
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = 32'hA0 + 32'(i);
        run_txn(1'b1, 1'b0, 32'h1000_0080, 32'h1000_0100, blk, 0, 1'b0, 1'b0, -1);

        // Randomized stalls; some fills read back a block just evicted.
        for (int t = 0; t < 8; t++) begin
            ea = $urandom;
            ma = ($urandom_range(0, 1) != 0) ? ea : $urandom;
            run_txn(1'($urandom_range(0, 1)), 1'b1, ea, ma, rand_blk(), 5, 1'b0, 1'b1, -1);
        end

        // Both requests together, miss pulses during the transfer.
        run_txn(1'b1, 1'b1, 32'h3000_0000, 32'h3000_0040, rand_blk(), 2, 1'b0, 1'b1, -1);

        // Reset mid-fill at beat 7, then a clean fill.
        run_txn(1'b0, 1'b1, 32'h0, 32'h4000_0000, '0, 0, 1'b0, 1'b0, 7);
        repeat (3) begin
            @(negedge clk);
            check_quiet("in_reset");
        end
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after_abort");
        run_txn(1'b0, 1'b1, 32'h0, 32'h4000_0000, '0, 0, 1'b0, 1'b0, -1);

        // Back-to-back fills with cacheMiss held.
        run_txn(1'b0, 1'b1, 32'h0, 32'h5000_0000, '0, 0, 1'b1, 1'b0, -1);
        run_txn(1'b0, 1'b1, 32'h0, 32'h6000_0040, '0, 0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
